acorn128_dec_core: RTL and testbench
====================================

Name: acorn128_dec_core

Overview:
- Bit-serial ACORN-128 (v3) authenticated-decryption engine; one 293-bit state step per clk.
- Loads key/IV, absorbs associated data, then decrypts a ciphertext byte stream into plaintext bytes, feeding the recovered plaintext bit back into the state.
- Finalizes, then compares the 128-bit tag.
- Receiver-side counterpart of the encrypt datapath; shares the same state-update, keystream and feedback equations.

Parameters:
- LEN_W, 16, width of the ad_len and ct_len byte counts.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin operation; sampled only in IDLE
- key  in  128  key; bit i = key[i]
- iv  in  128  IV; bit i = iv[i]
- tag_in  in  128  expected tag; bit i = tag_in[i]
- ad_len  in  LEN_W  AD length in bytes; sampled at start
- ct_len  in  LEN_W  ciphertext length in bytes; sampled at start
- in_valid  in  1  byte available on in_data
- in_ready  out  1  core accepts in_data this cycle
- in_data  in  8  AD byte during the AD phase, ciphertext byte during the CT phase
- pt_valid  out  1  one-cycle pulse; pt_data valid; no backpressure
- pt_data  out  8  recovered plaintext byte
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at completion
- tag_ok  out  1  computed tag == tag_in; valid with done, held until next start

Behaviour:
- Reset (async, rst=0): state S, counters and shift registers cleared. FSM=IDLE. Outputs in_ready=0, pt_valid=0, pt_data=0, busy=0, done=0, tag_ok=0. A reset mid-operation aborts immediately; no partial pt or done is emitted.
- Per step, with message bit m and controls ca, cb:
  - LFSR updates, in this order: S289^=S235^S230; S230^=S196^S193; S193^=S160^S154; S154^=S111^S107; S107^=S66^S61; S61^=S23^S0.
  - ks = S12^S154^maj(S235,S61,S193)^ch(S230,S111,S66), using the updated S.
  - f = S0^~S107^maj(S244,S23,S160)^(ca&S196)^(cb&ks)^m.
  - Shift S[i]=S[i+1]; S292=f.
- FSM states, with the counter value at which each exits:
  - IDLE: on start=1, latch key, iv, tag_in, ad_len and ct_len; S=0; go to LOAD.
  - LOAD: 256 steps. m = key bits 0..127, then iv bits 0..127. ca=cb=1.
  - INIT: 1536 steps. m = key[j mod 128], except step 0 uses key[0]^1. ca=cb=1.
  - AD: 8*ad_len steps, bytes processed LSB first. ca=cb=1. Skipped if ad_len=0.
  - ADPAD: 256 steps. m=1 at step 0, else 0. ca=1 for steps 0..127, ca=0 for steps 128..255. cb=1.
  - CT: 8*ct_len steps, LSB first. ca=1, cb=0. Plaintext bit p = c^ks and m=p. Skipped if ct_len=0.
  - CTPAD: 256 steps. Same m and ca as ADPAD, but cb=0.
  - FIN: 768 steps. m=0, ca=cb=1. Tag bit i = ks of FIN step 640+i.
  - DONE: one cycle. done=1, tag_ok updated, busy=0, then IDLE.
- Byte handshake (AD and CT phases):
  - in_ready=1 only on the step slot for bit 0 of a byte.
  - A transfer occurs when in_valid&in_ready. That cycle performs bit 0; the next 7 cycles perform bits 1..7 from a holding register.
  - If in_valid=0, the core stalls with no step and S is unchanged.
  - in_ready=0 in all other states.
- Plaintext output: pt_valid pulses and pt_data is presented the cycle after bit 7 of each CT byte is processed.
- Cycle counts with no stalls: start accepted at cycle 0 → done at cycle 3072+8*(ad_len+ct_len)+1.
- start asserted while busy is ignored.
- Step counter is 11 bits and rolls to 0 at each phase change.
- Byte counters count down the latched lengths; a wrap to all-ones is never reached.

Test Plan:
- ad_len=0, ct_len=0, key=iv=0, tag_in from the golden C model → done at cycle 3073, tag_ok=1, no pt_valid, in_ready never high.
- ad_len=2, ct_len=3, random key/iv, ciphertext and tag from the model's encrypt → 3 pt_valid pulses with bytes equal to the original plaintext, done at cycle 3113, tag_ok=1.
- Same stimulus with one ciphertext bit flipped → pt byte differs at the same bit, tag_ok=0.
- Same stimulus with tag_in[127] flipped → tag_ok=0.
- Insert 5-cycle in_valid=0 gaps before every byte → identical pt bytes and tag_ok. done is delayed by exactly 5 cycles per byte (25 cycles).
- rst pulsed low mid-INIT, then a fresh start → all outputs at reset values immediately. The following run matches the clean-run result, and start pulses during busy have no effect.

Source files
------------

// File: rtl/acorn128_dec_core.sv
// acorn128_dec_core: bit-serial ACORN-128 v3 authenticated decryption, one state step per clock.
module acorn128_dec_core #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     key,
    input  logic [127:0]     iv,
    input  logic [127:0]     tag_in,
    input  logic [LEN_W-1:0] ad_len,
    input  logic [LEN_W-1:0] ct_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             pt_valid,
    output logic [7:0]       pt_data,
    output logic             busy,
    output logic             done,
    output logic             tag_ok
);
    typedef enum logic [3:0] {IDLE, LOAD, INIT, AD, ADPAD, CT, CTPAD, FIN, DONE} state_t;
    state_t           state;
    logic [10:0]      cnt;
    logic [292:0]     s, u, s_nxt;
    logic [127:0]     key_l, iv_l, tag_l, tag_sr;
    logic [LEN_W-1:0] ad_rem, ct_rem;
    logic [7:0]       hold;
    logic [6:0]       pt_sr;
    logic [2:0]       bit_i;
    logic             ks, ca, cb, m, p, f, cbit, adv, pad;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic ch(input logic a, input logic b, input logic c);
        return (a & b) ^ (~a & c);
    endfunction

    // Each LFSR tap update reads only not-yet-updated bits, so all use pre-step values.
    always_comb begin
        bit_i = cnt[2:0];
        cbit = (bit_i == 3'd0) ? in_data[0] : hold[bit_i];
        adv = (bit_i != 3'd0) || in_valid;
        pad = (state == ADPAD) || (state == CTPAD);
        u = s;
        u[289] = s[289] ^ s[235] ^ s[230];
        u[230] = s[230] ^ s[196] ^ s[193];
        u[193] = s[193] ^ s[160] ^ s[154];
        u[154] = s[154] ^ s[111] ^ s[107];
        u[107] = s[107] ^ s[66] ^ s[61];
        u[61] = s[61] ^ s[23] ^ s[0];
        ks = u[12] ^ u[154] ^ maj(u[235], u[61], u[193]) ^ ch(u[230], u[111], u[66]);
        ca = !(pad && cnt[7]);
        cb = !((state == CT) || (state == CTPAD));
        p = cbit ^ ks;
        m = (state == LOAD) ? (cnt[7] ? iv_l[cnt[6:0]] : key_l[cnt[6:0]]) :
            (state == INIT) ? key_l[cnt[6:0]] ^ (cnt == 11'd0) :
            (state == AD)   ? cbit :
            (state == CT)   ? p :
            pad             ? (cnt == 11'd0) : 1'b0;
        f = u[0] ^ ~u[107] ^ maj(u[244], u[23], u[160]) ^ (ca & u[196]) ^ (cb & ks) ^ m;
        s_nxt = {f, u[292:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            s        <= '0;
            key_l    <= '0;
            iv_l     <= '0;
            tag_l    <= '0;
            tag_sr   <= '0;
            ad_rem   <= '0;
            ct_rem   <= '0;
            hold     <= '0;
            pt_sr    <= '0;
            in_ready <= 1'b0;
            pt_valid <= 1'b0;
            pt_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tag_ok   <= 1'b0;
        end else begin
            done     <= 1'b0;
            pt_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    key_l  <= key;
                    iv_l   <= iv;
                    tag_l  <= tag_in;
                    ad_rem <= ad_len;
                    ct_rem <= ct_len;
                    s      <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    tag_ok <= 1'b0;
                    state  <= LOAD;
                end
                LOAD: begin
                    s   <= s_nxt;
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd255) begin
                        cnt   <= '0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    s   <= s_nxt;
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd1535) begin
                        cnt      <= '0;
                        state    <= (ad_rem != '0) ? AD : ADPAD;
                        in_ready <= ad_rem != '0;
                    end
                end
                AD: if (adv) begin
                    s   <= s_nxt;
                    cnt <= cnt + 11'd1;
                    if (bit_i == 3'd0) begin
                        hold     <= in_data;
                        in_ready <= 1'b0;
                    end
                    if (bit_i == 3'd7) begin
                        ad_rem   <= ad_rem - 1'b1;
                        in_ready <= ad_rem != LEN_W'(1);
                        if (ad_rem == LEN_W'(1)) begin
                            cnt   <= '0;
                            state <= ADPAD;
                        end
                    end
                end
                ADPAD: begin
                    s   <= s_nxt;
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd255) begin
                        cnt      <= '0;
                        state    <= (ct_rem != '0) ? CT : CTPAD;
                        in_ready <= ct_rem != '0;
                    end
                end
                CT: if (adv) begin
                    s     <= s_nxt;
                    cnt   <= cnt + 11'd1;
                    pt_sr <= {p, pt_sr[6:1]};
                    if (bit_i == 3'd0) begin
                        hold     <= in_data;
                        in_ready <= 1'b0;
                    end
                    if (bit_i == 3'd7) begin
                        pt_data  <= {p, pt_sr};
                        pt_valid <= 1'b1;
                        ct_rem   <= ct_rem - 1'b1;
                        in_ready <= ct_rem != LEN_W'(1);
                        if (ct_rem == LEN_W'(1)) begin
                            cnt   <= '0;
                            state <= CTPAD;
                        end
                    end
                end
                CTPAD: begin
                    s   <= s_nxt;
                    cnt <= cnt + 11'd1;
                    if (cnt == 11'd255) begin
                        cnt   <= '0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    s   <= s_nxt;
                    cnt <= cnt + 11'd1;
                    if (cnt >= 11'd640) tag_sr <= {ks, tag_sr[127:1]};
                    if (cnt == 11'd767) begin
                        cnt    <= '0;
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        tag_ok <= {ks, tag_sr[127:1]} == tag_l;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acorn128_dec_core.sv
// tb_acorn128_dec_core: drives decryption runs whose ciphertext and tag come from a bench-side ACORN encrypt model.
module tb_acorn128_dec_core;
    localparam int LEN_W = 16;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [127:0]     key = '0, iv = '0, tag_in = '0;
    logic [LEN_W-1:0] ad_len = '0, ct_len = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready, pt_valid, busy, done, tag_ok;
    logic [7:0]       pt_data;

    acorn128_dec_core #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .tag_in(tag_in),
        .ad_len(ad_len), .ct_len(ct_len), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .pt_valid(pt_valid), .pt_data(pt_data), .busy(busy),
        .done(done), .tag_ok(tag_ok)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0, n_bad = 0;
    int           na, nc;
    bit           ms [0:292];
    logic [7:0]   ad_b [4], pt_b [4], ct_b [4], exp_pt [4];
    logic [127:0] tag_m;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference-style in-place update on a bit array, encrypt direction (m = plaintext).
    task automatic mstep(input bit mb, input bit ca, input bit cb, output bit ks);
        bit f;
        ms[289] ^= ms[235] ^ ms[230];
        ms[230] ^= ms[196] ^ ms[193];
        ms[193] ^= ms[160] ^ ms[154];
        ms[154] ^= ms[111] ^ ms[107];
        ms[107] ^= ms[66] ^ ms[61];
        ms[61]  ^= ms[23] ^ ms[0];
        ks = ms[12] ^ ms[154] ^ ((ms[235] & ms[61]) | (ms[235] & ms[193]) | (ms[61] & ms[193]))
             ^ ((ms[230] & ms[111]) | (~ms[230] & ms[66]));
        f = ms[0] ^ ~ms[107] ^ ((ms[244] & ms[23]) | (ms[244] & ms[160]) | (ms[23] & ms[160]))
            ^ (ca & ms[196]) ^ (cb & ks) ^ mb;
        for (int i = 0; i < 292; i++) ms[i] = ms[i + 1];
        ms[292] = f;
    endtask

    task automatic encrypt(input logic [127:0] k, input logic [127:0] v);
        bit ks;
        for (int i = 0; i < 293; i++) ms[i] = 1'b0;
        for (int i = 0; i < 128; i++) mstep(k[i], 1'b1, 1'b1, ks);
        for (int i = 0; i < 128; i++) mstep(v[i], 1'b1, 1'b1, ks);
        for (int i = 0; i < 1536; i++) mstep(k[i % 128] ^ (i == 0), 1'b1, 1'b1, ks);
        for (int a = 0; a < na; a++)
            for (int b = 0; b < 8; b++) mstep(ad_b[a][b], 1'b1, 1'b1, ks);
        for (int i = 0; i < 256; i++) mstep(i == 0, i < 128, 1'b1, ks);
        for (int a = 0; a < nc; a++)
            for (int b = 0; b < 8; b++) begin
                mstep(pt_b[a][b], 1'b1, 1'b0, ks);
                ct_b[a][b] = pt_b[a][b] ^ ks;
            end
        for (int i = 0; i < 256; i++) mstep(i == 0, i < 128, 1'b0, ks);
        for (int i = 0; i < 768; i++) begin
            mstep(1'b0, 1'b1, 1'b1, ks);
            if (i >= 640) tag_m[i - 640] = ks;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_pt_valid"}, pt_valid, 0);
        chk({pfx, "_pt_data"}, pt_data, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_tag_ok"}, tag_ok, 0);
    endtask

    // Cycle 1 is the first cycle after the edge that accepts start.
    task automatic run_dec(input string name, input int gap, input bit poke, input int exp_done, input bit exp_tag);
        int cyc, ai, ci, pi, g, dcyc;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        ad_len = LEN_W'(na);
        ct_len = LEN_W'(nc);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1; ai = 0; ci = 0; pi = 0; g = gap; dcyc = 0; seen = 1'b0;
        while (cyc < 4000 && dcyc == 0) begin
            if (cyc == 1) chk({name, "_busy_after_start"}, busy, 1);
            if (pt_valid) begin
                if (pi < nc) chk($sformatf("%s_pt%0d", name, pi), pt_data, exp_pt[pi]);
                pi++;
            end
            if (in_ready) seen = 1'b1;
            if (done) dcyc = cyc;
            in_valid = 1'b0;
            start = poke && (cyc % 700 == 0);
            if (in_ready && !done) begin
                if (g > 0) g--;
                else begin
                    in_valid = 1'b1;
                    in_data = (ai < na) ? ad_b[ai % 4] : ct_b[ci % 4];
                    if (ai < na) ai++;
                    else ci++;
                    g = gap;
                end
            end
            @(posedge clk);
            #1 cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk({name, "_done_cycle"}, dcyc, exp_done);
        chk({name, "_done_pulse_end"}, done, 0);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_tag_ok"}, tag_ok, exp_tag);
        chk({name, "_pt_count"}, pi, nc);
        chk({name, "_in_ready_seen"}, seen, (na + nc) != 0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset");
        #19 rst = 1'b1;

        na = 0; nc = 0; key = '0; iv = '0;
        encrypt(key, iv);
        tag_in = tag_m;
        run_dec("empty", 0, 1'b0, 3073, 1'b1);

        na = 2; nc = 3;
        key = {$urandom, $urandom, $urandom, $urandom};
        iv = {$urandom, $urandom, $urandom, $urandom};
        ad_b[0] = 8'h3a; ad_b[1] = 8'hc5;
        pt_b[0] = 8'h00; pt_b[1] = 8'hff; pt_b[2] = 8'h5e;
        encrypt(key, iv);
        tag_in = tag_m;
        for (int i = 0; i < 3; i++) exp_pt[i] = pt_b[i];
        run_dec("clean", 0, 1'b0, 3113, 1'b1);

        ct_b[2] ^= 8'h08;
        exp_pt[2] = pt_b[2] ^ 8'h08;
        run_dec("ctflip", 0, 1'b0, 3113, 1'b0);
        ct_b[2] ^= 8'h08;
        exp_pt[2] = pt_b[2];

        tag_in = tag_m ^ {1'b1, 127'd0};
        run_dec("tagflip", 0, 1'b0, 3113, 1'b0);
        tag_in = tag_m;

        run_dec("gaps", 5, 1'b0, 3138, 1'b1);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (500) @(posedge clk);
        #3 chk("midinit_busy_before_reset", busy, 1);
        rst = 1'b0;
        #1 check_reset_outputs("midinit_reset");
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        run_dec("after_reset", 0, 1'b1, 3113, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
